// File: rtl/byte_mem_pkg.sv
// Shared FSM state type and request-length helper for byte_mem_ctrl.
package byte_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic logic len_legal(input int len, input int word_bytes);
    return (len >= 1) && (len <= word_bytes);
  endfunction

endpackage

// File: rtl/byte_mem_array.sv
// DEPTH x 8 single-port storage: synchronous write, combinational read.
module byte_mem_array #(
  parameter  int DEPTH = 256,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/byte_mem_ctrl.sv
// Byte-serial big-endian memory controller; one byte moved per XFER cycle.
// Optional feature macro: BYTE_MEM_ALIGN_CHECK_EN (reject addr mod len != 0).
module byte_mem_ctrl
  import byte_mem_pkg::*;
#(
  parameter  int DEPTH      = 256,
  parameter  int WORD_BYTES = 4,
  localparam int AW         = $clog2(DEPTH),
  localparam int LW         = $clog2(WORD_BYTES) + 1,
  localparam int DW         = 8 * WORD_BYTES
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [LW-1:0] req_len,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err
);

  state_e        state;
  logic [LW-1:0] cnt;
  logic          err_q;
  logic [DW-1:0] rdata_q;

  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [LW-1:0] len_q;
  logic [DW-1:0] wdata_q;

  logic          accept;
  logic          req_bad;
  logic          last;
  logic [LW-1:0] byte_idx;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [7:0]    wr_byte;
  logic [7:0]    rd_byte;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign accept    = req_valid && req_ready;

  always_comb begin
    req_bad = !len_legal(int'(req_len), WORD_BYTES);
`ifdef BYTE_MEM_ALIGN_CHECK_EN
    if (!req_bad && ((int'(req_addr) % int'(req_len)) != 0)) req_bad = 1'b1;
`endif
  end

  // Byte i of the word sits at bit lane len-1-i, so the start address holds the MSB.
  assign byte_idx = len_q - LW'(1) - cnt;
  assign wr_byte  = 8'(wdata_q >> {byte_idx, 3'b000});
  assign mem_addr = addr_q + AW'(cnt);
  assign mem_we   = (state == XFER) && we_q;
  assign last     = (cnt == len_q - LW'(1));

  byte_mem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (wr_byte),
    .rdata (rd_byte)
  );

  // Request fields are captured only at acceptance and carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      len_q   <= req_len;
      wdata_q <= req_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cnt     <= '0;
            rdata_q <= '0;
            err_q   <= req_bad;
            state   <= req_bad ? RESP : XFER;
          end
        end
        XFER: begin
          // Reads shift in MSB-first, leaving the result right-justified.
          if (!we_q) rdata_q <= (rdata_q << 8) | DW'(rd_byte);
          if (last) begin
            cnt   <= '0;
            state <= RESP;
          end else begin
            cnt <= cnt + LW'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            err_q <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_byte_mem_ctrl.sv
// Self-checking bench for byte_mem_ctrl (DEPTH=8, WORD_BYTES=4) against a byte-array model.
module tb_byte_mem_ctrl;

  localparam int DEPTH = 8;
  localparam int WB    = 4;
  localparam int AW    = 3;
  localparam int LW    = 3;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [LW-1:0] req_len;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  int checks   = 0;
  int failures = 0;

  logic [7:0] ref_mem [DEPTH];

  always #5 clk = ~clk;

  byte_mem_ctrl #(
    .DEPTH      (DEPTH),
    .WORD_BYTES (WB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic exp_err(input int addr, input int len);
    if (len < 1 || len > WB) return 1'b1;
`ifdef BYTE_MEM_ALIGN_CHECK_EN
    if ((addr % len) != 0) return 1'b1;
`endif
    return 1'b0;
  endfunction

  task automatic run(input logic we, input int addr, input int len, input logic [31:0] wdata,
                     input int hold, output logic [31:0] rd, output logic er);
    logic [31:0] exp_rd;
    logic        e_err;
    int          exp_lat;
    int          lat;
    e_err  = exp_err(addr, len);
    exp_rd = '0;
    if (!e_err && !we)
      for (int i = 0; i < len; i++) exp_rd = (exp_rd << 8) | 32'(ref_mem[(addr + i) % DEPTH]);
    exp_lat = e_err ? 1 : len + 1;

    @(negedge clk);
    check_eq("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = AW'(addr);
    req_len   = LW'(len);
    req_wdata = wdata;
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      req_valid = 1'b0;
      lat++;
    end while (!rsp_valid && lat < 20);
    check_eq("latency", 32'(lat), 32'(exp_lat));
    rd = rsp_rdata;
    er = rsp_err;
    check_eq("rsp_err", 32'(er), 32'(e_err));
    check_eq("rsp_rdata", rd, exp_rd);

    // Offer a competing request while the response is stalled.
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_wdata = ~wdata;
      @(negedge clk);
      check_eq("hold_valid", 32'(rsp_valid), 32'd1);
      check_eq("hold_rdata", rsp_rdata, rd);
      check_eq("hold_err", 32'(rsp_err), 32'(er));
      check_eq("hold_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check_eq("post_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("post_req_ready", 32'(req_ready), 32'd1);

    if (we && !e_err)
      for (int i = 0; i < len; i++)
        ref_mem[(addr + i) % DEPTH] = 8'(wdata >> (8 * (len - 1 - i)));
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [7:0]  pre [8];
    pre = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;

    rst       = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_len   = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_req_ready", 32'(req_ready), 32'd1);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rsp_err", 32'(rsp_err), 32'd0);
    check_eq("rst_rsp_rdata", rsp_rdata, 32'd0);
    rst = 1'b1;

    for (int a = 0; a < DEPTH; a++) run(1'b1, a, 1, 32'(pre[a]), 0, rd, er);

    run(1'b0, 3, 4, 32'h0, 0, rd, er);
`ifndef BYTE_MEM_ALIGN_CHECK_EN
    check_eq("read_a3_l4", rd, 32'h789ABCDE);
`endif
    run(1'b0, 6, 4, 32'h0, 0, rd, er);
`ifdef BYTE_MEM_ALIGN_CHECK_EN
    check_eq("wrap_align_err", 32'(er), 32'd1);
`else
    check_eq("wrap_read", rd, 32'hDEF01234);
`endif
    run(1'b1, 1, 2, 32'h0000BEEF, 0, rd, er);
    run(1'b0, 0, 4, 32'h0, 0, rd, er);
`ifndef BYTE_MEM_ALIGN_CHECK_EN
    check_eq("after_beef", rd, 32'h12BEEF78);
`endif
    run(1'b0, 0, 4, 32'h0, 3, rd, er);

    run(1'b1, 2, 0, 32'hFFFFFFFF, 0, rd, er);
    run(1'b1, 0, WB + 1, 32'hFFFFFFFF, 1, rd, er);
    for (int a = 0; a < DEPTH; a++) run(1'b0, a, 1, 32'h0, 0, rd, er);

    // Abort a 4-byte write after its second byte has been committed.
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = AW'(4);
    req_len   = LW'(4);
    req_wdata = 32'hAABBCCDD;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("abort_no_rsp1", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check_eq("abort_no_rsp2", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("abort_rst_ready", 32'(req_ready), 32'd1);
    check_eq("abort_rst_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_eq("abort_rel_valid", 32'(rsp_valid), 32'd0);
      check_eq("abort_rel_ready", 32'(req_ready), 32'd1);
    end
    ref_mem[4] = 8'hAA;
    ref_mem[5] = 8'hBB;
    for (int a = 4; a < DEPTH; a++) run(1'b0, a, 1, 32'h0, 0, rd, er);
    run(1'b0, 4, 4, 32'h0, 0, rd, er);

    for (int n = 0; n < 80; n++) begin
      run(1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)),
          int'($urandom_range(0, WB + 1)), $urandom, int'($urandom_range(0, 2)), rd, er);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
